// File: rtl/ibuffer_loader.sv
// ---------------------------------------------------------------------------
// ibuffer_loader
//
// Write side of the per-PE instruction buffer. A narrow valid/ready stream
// is assembled into dataLen-bit words, least-significant beat first. Every
// packet opens with a header word carrying a target PE id and a word count.
// Packets addressed to peId are written to the instruction memory from
// address 0 upward. Packets for other PEs are consumed and dropped.
//
// Header word layout:
//   [dataLen-1 -: idBits]  target PE
//   [addrLen:0]            word count, legal range 1..DEPTH
//   all other bits         ignored
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   inData    stream beat (inWidth bits)
//   inValid   beat valid
//   inReady   beat accepted when inValid && inReady
//   wrEn      instruction memory write strobe
//   wrAddr    write address (addrLen bits)
//   wrData    write data (dataLen bits), holds value while wrEn=0
//   busy      high from the first accepted header beat until the packet ends
//   loadDone  one-cycle pulse with the final write of a matching packet
//   hdrError  one-cycle pulse after a header with an illegal count
// ---------------------------------------------------------------------------
module ibuffer_loader #(
    parameter int addrLen = 5,
    parameter int dataLen = 32,
    parameter int inWidth = 16,
    parameter int peId    = 1,
    parameter int idBits  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [inWidth-1:0] inData,
    input  logic               inValid,
    output logic               inReady,
    output logic               wrEn,
    output logic [addrLen-1:0] wrAddr,
    output logic [dataLen-1:0] wrData,
    output logic               busy,
    output logic               loadDone,
    output logic               hdrError
);

    localparam int BEATS = dataLen / inWidth;
    localparam int DEPTH = 1 << addrLen;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Count field is one bit wider than the address so that DEPTH fits.
    localparam int CW    = addrLen + 1;

    localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
    localparam logic [BW-1:0]     BEAT_ONE  = BW'(1);
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]     CNT_ZERO  = '0;
    localparam logic [CW-1:0]     DEPTH_C   = CW'(DEPTH);
    localparam logic [idBits-1:0] PE_ID     = idBits'(peId);

    typedef enum logic [1:0] {
        HEADER = 2'd0,
        LOAD   = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;

    logic [BW-1:0]      beat_cnt;
    logic [CW-1:0]      word_cnt;
    logic [CW-1:0]      count_q;
    logic               match_q;
    logic [dataLen-1:0] asm_q;

    logic [dataLen-1:0] word_cur;
    logic [CW-1:0]      hdr_count;
    logic               hdr_match;
    logic               hs;
    logic               word_done;
    logic               hdr_bad;
    logic               hdr_ok;
    logic               data_done;
    logic               last_word;

    // Next state and per-cycle strobes
    always_comb begin
        state_nx  = state;
        inReady   = 1'b1;
        hs        = 1'b0;
        word_done = 1'b0;
        hdr_bad   = 1'b0;
        hdr_ok    = 1'b0;
        data_done = 1'b0;
        last_word = 1'b0;

        // Word as it would look with the current beat merged in; on the
        // last beat this is the completed word, usable in the same cycle.
        word_cur = asm_q;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_cnt == BW'(b)) begin
                word_cur[b*inWidth +: inWidth] = inData;
            end
        end
        hdr_count = word_cur[CW-1:0];
        hdr_match = (word_cur[dataLen-1 -: idBits] == PE_ID);

        // The single DONE cycle holds off the next packet's first beat.
        inReady   = (state != DONE);
        hs        = inValid && inReady;
        word_done = hs && (beat_cnt == LAST_BEAT);

        case (state)
            HEADER: begin
                if (word_done) begin
                    hdr_bad = (hdr_count == CNT_ZERO) || (hdr_count > DEPTH_C);
                    hdr_ok  = !hdr_bad;
                    if (!hdr_bad) begin
                        state_nx = LOAD;
                    end
                end
            end
            LOAD: begin
                if (word_done) begin
                    data_done = 1'b1;
                    last_word = ((word_cnt + CNT_ONE) == count_q);
                    if (last_word) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = HEADER;
            end
            default: begin
                state_nx = HEADER;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= HEADER;
        end else begin
            state <= state_nx;
        end
    end

    // Beat and word counters, latched header fields
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt <= '0;
            word_cnt <= '0;
            count_q  <= '0;
            match_q  <= 1'b0;
        end else begin
            if (hs) begin
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_ONE;
            end
            if (hdr_ok) begin
                count_q  <= hdr_count;
                match_q  <= hdr_match;
                word_cnt <= '0;
            end else if (data_done) begin
                word_cnt <= word_cnt + CNT_ONE;
            end
        end
    end

    // Partial word storage; stale contents are always overwritten before
    // they can reach an output, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (hs) begin
            asm_q <= word_cur;
        end
    end

    // Registered outputs: every strobe appears one cycle after the
    // handshake that completes its word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrEn     <= 1'b0;
            wrAddr   <= '0;
            wrData   <= '0;
            busy     <= 1'b0;
            loadDone <= 1'b0;
            hdrError <= 1'b0;
        end else begin
            wrEn     <= data_done && match_q;
            loadDone <= last_word && match_q;
            hdrError <= hdr_bad;

            if (data_done && match_q) begin
                wrAddr <= word_cnt[addrLen-1:0];
                wrData <= word_cur;
            end else if (state == DONE) begin
                wrAddr <= '0;
            end

            // A rejected header drops busy in the same cycle hdrError pulses.
            if (state == HEADER && hs) begin
                busy <= !hdr_bad;
            end else if (state == DONE) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ibuffer_loader.sv
module tb_ibuffer_loader;

    logic        clk;
    logic        reset_n;
    logic [15:0] inData;
    logic        inValid;
    logic        inReady;
    logic        wrEn;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic        busy;
    logic        loadDone;
    logic        hdrError;

    ibuffer_loader #(
        .addrLen(5),
        .dataLen(32),
        .inWidth(16),
        .peId(1),
        .idBits(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .inData(inData),
        .inValid(inValid),
        .inReady(inReady),
        .wrEn(wrEn),
        .wrAddr(wrAddr),
        .wrData(wrData),
        .busy(busy),
        .loadDone(loadDone),
        .hdrError(hdrError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle counter and negedge event log
    int          cyc = 0;
    logic [4:0]  wa[16];
    logic [31:0] wd[16];
    int          wc[16];
    int          hsc[16];
    int          nw, nh, nld, nhe, nbusy, nrdy0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (wrEn) begin
                if (nw < 16) begin
                    wa[nw] = wrAddr;
                    wd[nw] = wrData;
                    wc[nw] = cyc;
                end
                nw++;
            end
            if (inValid && inReady) begin
                if (nh < 16) hsc[nh] = cyc;
                nh++;
            end
            if (loadDone) nld++;
            if (hdrError) nhe++;
            if (busy) nbusy++;
            if (!inReady) nrdy0++;
        end
    end

    task automatic clr();
        nw = 0; nh = 0; nld = 0; nhe = 0; nbusy = 0; nrdy0 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left 1 time unit after a rising edge. Leaves inValid high
    // so consecutive calls form a gap-free stream.
    task automatic send(input logic [15:0] d, input int idle);
        int n;
        for (int i = 0; i < idle; i++) begin
            inValid = 1'b0;
            tick();
        end
        inData  = d;
        inValid = 1'b1;
        n = 0;
        while (!inReady && n < 4) begin
            tick();
            n++;
        end
        if (n >= 4) check_eq("ready_timeout", 64'(inReady), 64'(1));
        tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int idle);
        send(w[15:0], idle);
        send(w[31:16], idle);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        inData  = '0;
        inValid = 1'b0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_inReady",  64'(inReady),  64'(1));
        check_eq("rst_wrEn",     64'(wrEn),     64'(0));
        check_eq("rst_wrAddr",   64'(wrAddr),   64'(0));
        check_eq("rst_wrData",   64'(wrData),   64'(0));
        check_eq("rst_busy",     64'(busy),     64'(0));
        check_eq("rst_loadDone", 64'(loadDone), 64'(0));
        check_eq("rst_hdrError", 64'(hdrError), 64'(0));
        reset_n = 1'b1;
        tick();

        // Matching load, no stalls
        clr();
        send(16'h0003, 0);
        check_eq("s1_busy_rise", 64'(busy), 64'(1));
        send(16'h0100, 0);
        send_word(32'hDEADBEEF, 0);
        send_word(32'h12345678, 0);
        send_word(32'hCAFE0000, 0);
        inValid = 1'b0;
        check_eq("s1_done_wrEn",     64'(wrEn),     64'(1));
        check_eq("s1_done_wrAddr",   64'(wrAddr),   64'(2));
        check_eq("s1_done_wrData",   64'(wrData),   64'h0000_0000_CAFE_0000);
        check_eq("s1_done_loadDone", 64'(loadDone), 64'(1));
        check_eq("s1_done_busy",     64'(busy),     64'(1));
        check_eq("s1_done_inReady",  64'(inReady),  64'(0));
        tick();
        check_eq("s1_after_busy",     64'(busy),     64'(0));
        check_eq("s1_after_wrEn",     64'(wrEn),     64'(0));
        check_eq("s1_after_loadDone", 64'(loadDone), 64'(0));
        check_eq("s1_after_wrData",   64'(wrData),   64'h0000_0000_CAFE_0000);
        check_eq("s1_nw", 64'(nw), 64'(3));
        check_eq("s1_wa0", 64'(wa[0]), 64'(0));
        check_eq("s1_wd0", 64'(wd[0]), 64'h0000_0000_DEAD_BEEF);
        check_eq("s1_wa1", 64'(wa[1]), 64'(1));
        check_eq("s1_wd1", 64'(wd[1]), 64'h0000_0000_1234_5678);
        check_eq("s1_wa2", 64'(wa[2]), 64'(2));
        check_eq("s1_wd2", 64'(wd[2]), 64'h0000_0000_CAFE_0000);
        check_eq("s1_lat0", 64'(wc[0]), 64'(hsc[3] + 1));
        check_eq("s1_lat2", 64'(wc[2]), 64'(hsc[7] + 1));
        check_eq("s1_nld", 64'(nld), 64'(1));
        check_eq("s1_nbusy", 64'(nbusy), 64'(8));

        // Non-matching packet
        clr();
        send_word(32'h0200_0002, 0);
        send_word(32'h2222_1111, 0);
        send_word(32'h4444_3333, 0);
        inValid = 1'b0;
        check_eq("s2_done_inReady",  64'(inReady),  64'(0));
        check_eq("s2_done_loadDone", 64'(loadDone), 64'(0));
        tick();
        check_eq("s2_nh", 64'(nh), 64'(6));
        check_eq("s2_nw", 64'(nw), 64'(0));
        check_eq("s2_nld", 64'(nld), 64'(0));
        check_eq("s2_nbusy", 64'(nbusy), 64'(6));
        check_eq("s2_nrdy0", 64'(nrdy0), 64'(1));

        // Illegal headers, then a legal one-word packet
        clr();
        send(16'h0000, 0);
        check_eq("s3_busy_rise", 64'(busy), 64'(1));
        send(16'h0100, 0);
        inValid = 1'b0;
        check_eq("s3_err0", 64'(hdrError), 64'(1));
        check_eq("s3_err0_busy", 64'(busy), 64'(0));
        check_eq("s3_err0_inReady", 64'(inReady), 64'(1));
        tick();
        check_eq("s3_err_pulse", 64'(hdrError), 64'(0));
        send_word(32'h0100_0021, 0);
        inValid = 1'b0;
        check_eq("s3_err33", 64'(hdrError), 64'(1));
        tick();
        send_word(32'h0100_0001, 0);
        send_word(32'h5A5A_A5A5, 0);
        inValid = 1'b0;
        check_eq("s3_wrEn",   64'(wrEn),   64'(1));
        check_eq("s3_wrAddr", 64'(wrAddr), 64'(0));
        check_eq("s3_wrData", 64'(wrData), 64'h0000_0000_5A5A_A5A5);
        tick();
        check_eq("s3_nhe", 64'(nhe), 64'(2));
        check_eq("s3_nw", 64'(nw), 64'(1));
        check_eq("s3_nld", 64'(nld), 64'(1));

        // Throttled input
        clr();
        send_word(32'h0100_0003, 1);
        send_word(32'hDEADBEEF, 1);
        send_word(32'h12345678, 1);
        send_word(32'hCAFE0000, 1);
        inValid = 1'b0;
        tick();
        check_eq("s4_nw", 64'(nw), 64'(3));
        check_eq("s4_wd0", 64'(wd[0]), 64'h0000_0000_DEAD_BEEF);
        check_eq("s4_wa1", 64'(wa[1]), 64'(1));
        check_eq("s4_wd1", 64'(wd[1]), 64'h0000_0000_1234_5678);
        check_eq("s4_wd2", 64'(wd[2]), 64'h0000_0000_CAFE_0000);
        check_eq("s4_gap", 64'(hsc[1] - hsc[0]), 64'(2));
        check_eq("s4_lat0", 64'(wc[0]), 64'(hsc[3] + 1));
        check_eq("s4_lat1", 64'(wc[1]), 64'(hsc[5] + 1));
        check_eq("s4_lat2", 64'(wc[2]), 64'(hsc[7] + 1));
        check_eq("s4_nld", 64'(nld), 64'(1));

        // Back-to-back packets with inValid held high
        clr();
        send_word(32'h0100_0001, 0);
        send_word(32'hAAAA_BBBB, 0);
        send_word(32'h0100_0001, 0);
        send_word(32'h1111_2222, 0);
        inValid = 1'b0;
        tick();
        check_eq("s5_nrdy0", 64'(nrdy0), 64'(2));
        check_eq("s5_holdoff", 64'(hsc[4] - hsc[3]), 64'(2));
        check_eq("s5_nw", 64'(nw), 64'(2));
        check_eq("s5_wa0", 64'(wa[0]), 64'(0));
        check_eq("s5_wd0", 64'(wd[0]), 64'h0000_0000_AAAA_BBBB);
        check_eq("s5_wa1", 64'(wa[1]), 64'(0));
        check_eq("s5_wd1", 64'(wd[1]), 64'h0000_0000_1111_2222);
        check_eq("s5_nld", 64'(nld), 64'(2));

        // Reset in the middle of a load
        clr();
        send_word(32'h0100_0003, 0);
        send_word(32'h0BAD_F00D, 0);
        send_word(32'h7777_8888, 0);
        inValid = 1'b0;
        check_eq("s6_pre_wrAddr", 64'(wrAddr), 64'(1));
        check_eq("s6_pre_nw", 64'(nw), 64'(1));
        reset_n = 1'b0;
        #1;
        check_eq("s6_rst_wrEn",    64'(wrEn),    64'(0));
        check_eq("s6_rst_wrAddr",  64'(wrAddr),  64'(0));
        check_eq("s6_rst_wrData",  64'(wrData),  64'(0));
        check_eq("s6_rst_busy",    64'(busy),    64'(0));
        check_eq("s6_rst_inReady", 64'(inReady), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        clr();
        send_word(32'h0100_0001, 0);
        send_word(32'h600D_CAFE, 0);
        inValid = 1'b0;
        tick();
        check_eq("s6_nw", 64'(nw), 64'(1));
        check_eq("s6_wa0", 64'(wa[0]), 64'(0));
        check_eq("s6_wd0", 64'(wd[0]), 64'h0000_0000_600D_CAFE);
        check_eq("s6_nld", 64'(nld), 64'(1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
